// File: rtl/euler_step_sequencer.sv
// Step sequencer for an Euler integration core: launches one core step at a time and advances t_now by h_step.
// Optional watchdog on the core finish level is enabled by defining EULER_SEQ_TIMEOUT_EN.
module euler_step_sequencer #(
  parameter int DATA_SIZE      = 16,
  parameter int STEP_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic                 abort,
  input  logic [DATA_SIZE-1:0] h_step,
  input  logic [DATA_SIZE-1:0] t_start,
  input  logic [DATA_SIZE-1:0] t_end,
  input  logic [STEP_W-1:0]    max_steps,
  input  logic                 core_finish,
  output logic                 core_start,
  output logic [DATA_SIZE-1:0] core_h_step,
  output logic [DATA_SIZE-1:0] t_now,
  output logic [STEP_W-1:0]    step_count,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LAUNCH   = 3'd1,
    WAIT_FIN = 3'd2,
    ADVANCE  = 3'd3,
    FINISH   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [DATA_SIZE-1:0] h_q, h_d;
  logic [DATA_SIZE-1:0] t_end_q, t_end_d;
  logic [DATA_SIZE-1:0] t_now_q, t_now_d;
  logic [STEP_W-1:0]    max_q, max_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic                 err_q, err_d;
  logic [DATA_SIZE:0]   sum;
  logic [STEP_W-1:0]    step_inc;

`ifdef EULER_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  assign sum      = {1'b0, t_now_q} + {1'b0, h_q};
  assign step_inc = step_q + STEP_W'(1);

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    t_end_d = t_end_q;
    t_now_d = t_now_q;
    max_d   = max_q;
    step_d  = step_q;
    err_d   = err_q;
`ifdef EULER_SEQ_TIMEOUT_EN
    wd_d    = wd_q;
`endif

    case (state_q)
      IDLE: begin
        if (go && !abort) begin
          h_d     = h_step;
          t_end_d = t_end;
          max_d   = max_steps;
          t_now_d = t_start;
          step_d  = '0;
          err_d   = 1'b0;
          if (max_steps == '0 || t_start >= t_end) state_d = FINISH;
          else                                     state_d = LAUNCH;
        end
      end
      LAUNCH: begin
`ifdef EULER_SEQ_TIMEOUT_EN
        wd_d = '0;
`endif
        state_d = abort ? IDLE : WAIT_FIN;
      end
      WAIT_FIN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (core_finish) begin
          state_d = ADVANCE;
        end else begin
`ifdef EULER_SEQ_TIMEOUT_EN
          if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            err_d   = 1'b1;
            state_d = FINISH;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
`endif
        end
      end
      ADVANCE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          step_d = step_inc;
          // A carry out of the time sum means t_now can no longer represent the run.
          if (sum[DATA_SIZE]) begin
            t_now_d = '1;
            err_d   = 1'b1;
            state_d = FINISH;
          end else begin
            t_now_d = sum[DATA_SIZE-1:0];
            if (step_inc == max_q || sum[DATA_SIZE-1:0] >= t_end_q) state_d = FINISH;
            else                                                    state_d = LAUNCH;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      h_q     <= '0;
      t_end_q <= '0;
      t_now_q <= '0;
      max_q   <= '0;
      step_q  <= '0;
      err_q   <= 1'b0;
`ifdef EULER_SEQ_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      t_end_q <= t_end_d;
      t_now_q <= t_now_d;
      max_q   <= max_d;
      step_q  <= step_d;
      err_q   <= err_d;
`ifdef EULER_SEQ_TIMEOUT_EN
      wd_q    <= wd_d;
`endif
    end
  end

  assign core_start  = (state_q == LAUNCH);
  assign done        = (state_q == FINISH);
  assign busy        = (state_q != IDLE);
  assign core_h_step = h_q;
  assign t_now       = t_now_q;
  assign step_count  = step_q;
  assign error       = err_q;

endmodule

// File: tb/tb_euler_step_sequencer.sv
// Self-checking bench for euler_step_sequencer: a simple Euler core model plus an arithmetic reference of each run.
// Timeout expectations follow EULER_SEQ_TIMEOUT_EN.
module tb_euler_step_sequencer;

  logic        clk = 1'b0;
  logic        rst, go, abort, core_finish;
  logic [15:0] h_step, t_start, t_end, max_steps;
  logic        core_start, busy, done, error;
  logic [15:0] core_h_step, t_now, step_count;

  int tests = 0;
  int fails = 0;

  int core_lat  = 5;
  bit core_hang = 1'b0;
  int core_cnt  = 0;

  int  r_starts, r_dones, r_first_start, r_done_cycle;
  bit  r_h_ok;

  euler_step_sequencer #(.DATA_SIZE(16), .STEP_W(16), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .go(go), .abort(abort),
    .h_step(h_step), .t_start(t_start), .t_end(t_end), .max_steps(max_steps),
    .core_finish(core_finish), .core_start(core_start), .core_h_step(core_h_step),
    .t_now(t_now), .step_count(step_count), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Core model: a start pulse drops the finish level, which rises core_lat cycles later unless the core hangs.
  always @(posedge clk) begin
    if (rst) begin
      core_finish <= 1'b0;
      core_cnt    <= 0;
    end else if (core_start) begin
      core_finish <= 1'b0;
      core_cnt    <= core_lat;
    end else if (core_cnt > 1) begin
      core_cnt <= core_cnt - 1;
    end else if (core_cnt == 1) begin
      core_cnt    <= 0;
      core_finish <= !core_hang;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walks the run with plain integer time arithmetic.
  function automatic void model(input int h, input int ts, input int te, input int ms,
                                output int steps, output int tn, output int er);
    int t;
    t = ts; steps = 0; er = 0;
    if (ms != 0 && ts < te) begin
      forever begin
        steps++;
        if (t + h > 65535) begin
          t = 65535; er = 1; break;
        end
        t = t + h;
        if (steps == ms || t >= te) break;
      end
    end
    tn = t;
  endfunction

  task automatic applyStimulus(input int h, input int ts, input int te, input int ms,
                               input bit inject, input int budget);
    int cyc;
    @(negedge clk);
    h_step = h[15:0]; t_start = ts[15:0]; t_end = te[15:0]; max_steps = ms[15:0];
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    cyc = 1; r_starts = 0; r_dones = 0; r_first_start = -1; r_done_cycle = -1; r_h_ok = 1'b1;
    while (cyc < budget && r_done_cycle < 0) begin
      if (core_start) begin
        r_starts++;
        if (r_first_start < 0) r_first_start = cyc;
      end
      if (core_h_step !== h[15:0]) r_h_ok = 1'b0;
      if (done) begin
        r_dones++;
        r_done_cycle = cyc;
      end
      if (inject && cyc == 2) begin
        go = 1'b1;
        h_step = h_step ^ 16'h0101; t_start = t_start ^ 16'h00F0;
        t_end = t_end ^ 16'h8000; max_steps = max_steps + 16'd1;
      end else begin
        go = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    go = 1'b0;
  endtask

  task automatic runCase(input string tag, input int h, input int ts, input int te, input int ms);
    int  steps, tn, er;
    bit  busy_after;
    model(h, ts, te, ms, steps, tn, er);
    applyStimulus(h, ts, te, ms, steps > 0, 3000);
    busy_after = busy;
    for (int i = 0; i < 3; i++) begin
      r_dones  += int'(done);
      r_starts += int'(core_start);
      @(negedge clk);
    end
    checkOutput($sformatf("%s.done_seen", tag), r_done_cycle >= 0, 1);
    checkOutput($sformatf("%s.core_starts", tag), r_starts, steps);
    checkOutput($sformatf("%s.step_count", tag), step_count, steps);
    checkOutput($sformatf("%s.t_now", tag), t_now, tn);
    checkOutput($sformatf("%s.error", tag), error, er);
    checkOutput($sformatf("%s.done_pulses", tag), r_dones, 1);
    checkOutput($sformatf("%s.busy_after", tag), busy_after, 0);
    checkOutput($sformatf("%s.core_h_step", tag), r_h_ok, 1);
    if (steps > 0) checkOutput($sformatf("%s.go_to_start", tag), r_first_start, 1);
    else           checkOutput($sformatf("%s.zero_done_latency", tag), (r_done_cycle >= 1 && r_done_cycle <= 2), 1);
  endtask

  initial begin
    int n, k, dsum;
    bit reached;
    rst = 1'b1; go = 1'b0; abort = 1'b0;
    h_step = '0; t_start = '0; t_end = '0; max_steps = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.done", done, 0);
    checkOutput("reset.core_start", core_start, 0);
    checkOutput("reset.error", error, 0);
    checkOutput("reset.t_now", t_now, 0);
    checkOutput("reset.step_count", step_count, 0);
    checkOutput("reset.core_h_step", core_h_step, 0);

    core_lat = 5;
    runCase("step_limit", 16'h0100, 16'h0000, 16'hFFFF, 3);
    runCase("end_time",   16'h0100, 16'h0000, 16'h0250, 10);
    runCase("zero_max",   16'h0100, 16'h0000, 16'h1000, 0);
    runCase("zero_order", 16'h0100, 16'h0500, 16'h0400, 5);
    runCase("overflow",   16'h0200, 16'hFF00, 16'hFFFF, 5);
    core_lat = 2;
    runCase("h_zero",     16'h0000, 16'h0010, 16'h0020, 4);

    for (int i = 0; i < 16; i++) begin
      core_lat = $urandom_range(1, 6);
      runCase($sformatf("rand%0d", i), $urandom_range(0, 16'h0600), $urandom_range(0, 16'hFFFF),
              $urandom_range(0, 16'hFFFF), $urandom_range(0, 8));
    end

    // Abort raised in WAIT_FIN in the same cycle the core reports finish for step 2.
    core_lat = 4;
    @(negedge clk);
    h_step = 16'h0100; t_start = 16'h0000; t_end = 16'hFFFF; max_steps = 16'd10; go = 1'b1;
    @(negedge clk);
    go = 1'b0; n = 0; reached = 1'b0;
    for (k = 0; k < 200 && !reached; k++) begin
      if (n == 2 && core_finish && busy) reached = 1'b1;
      else begin
        if (core_start) n++;
        @(negedge clk);
      end
    end
    checkOutput("abort.reached_wait", reached, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort.busy", busy, 0);
    checkOutput("abort.step_count", step_count, 1);
    checkOutput("abort.t_now", t_now, 16'h0100);
    dsum = int'(done);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dsum += int'(done);
    end
    checkOutput("abort.no_done", dsum, 0);

    // Reset in the middle of a run.
    core_lat = 3;
    applyStimulus(16'h0100, 16'h0000, 16'hFFFF, 10, 1'b0, 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst.busy", busy, 0);
    checkOutput("midrst.done", done, 0);
    checkOutput("midrst.core_start", core_start, 0);
    checkOutput("midrst.t_now", t_now, 0);
    checkOutput("midrst.step_count", step_count, 0);
    checkOutput("midrst.core_h_step", core_h_step, 0);
    checkOutput("midrst.error", error, 0);

    // Core that never finishes.
    core_hang = 1'b1; core_lat = 2;
`ifdef EULER_SEQ_TIMEOUT_EN
    applyStimulus(16'h0100, 16'h0040, 16'hFFFF, 5, 1'b0, 200);
    checkOutput("timeout.done_seen", r_done_cycle >= 0, 1);
    checkOutput("timeout.wait_cycles", r_done_cycle - r_first_start - 1, 8);
    checkOutput("timeout.error", error, 1);
    checkOutput("timeout.step_count", step_count, 0);
    checkOutput("timeout.t_now", t_now, 16'h0040);
    @(negedge clk);
    checkOutput("timeout.busy_after", busy, 0);
`else
    applyStimulus(16'h0100, 16'h0040, 16'hFFFF, 5, 1'b0, 60);
    checkOutput("hang.no_done", r_dones, 0);
    checkOutput("hang.busy", busy, 1);
    checkOutput("hang.error", error, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("hang.abort_idle", busy, 0);
`endif
    core_hang = 1'b0;
    core_lat = 3;
    runCase("after_hang", 16'h0080, 16'h0000, 16'h0100, 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
